// File: rtl/c17_bist_pkg.sv
// Shared types and helpers for the C17 BIST sequencer and its golden model.
// Latency: none; package only.
// Backpressure: none; package only.
package c17_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // MISR feedback taps: x^8 + x^4 + x^3 + x^2 + 1
    localparam logic [7:0] MISR_POLY = 8'h1D;

    // Pattern bit positions: pat = {G5gat,G4gat,G3gat,G2gat,G1gat}
    localparam int G1_BIT = 0;
    localparam int G2_BIT = 1;
    localparam int G3_BIT = 2;
    localparam int G4_BIT = 3;
    localparam int G5_BIT = 4;

    // Fault-free C17 response, returned as {G7gat,G6gat}
    function automatic logic [1:0] c17_resp(input logic [4:0] pat);
        logic w1, w2, w3, w4, g6, g7;
        w1 = ~(pat[G5_BIT] & pat[G2_BIT]);
        w2 = ~(pat[G5_BIT] & pat[G1_BIT]);
        w3 = ~(w1 & pat[G4_BIT]);
        w4 = ~(w1 & pat[G3_BIT]);
        g6 = ~(w2 & w3);
        g7 = ~(w4 & w3);
        return {g7, g6};
    endfunction

    // One MISR compaction step folding a 2-bit response into the signature
    function automatic logic [7:0] misr_step(input logic [7:0] sig, input logic [1:0] resp);
        return {sig[6:0], 1'b0} ^ (sig[7] ? MISR_POLY : 8'h00) ^ {6'b0, resp};
    endfunction

endpackage

// File: rtl/c17_bist_ctrl_if.sv
// Software-facing control/status bundle of the C17 BIST sequencer.
// Latency: wires only.
// Backpressure: none; start/abort are single-cycle requests, status is level.
interface c17_bist_ctrl_if #(
    parameter int ERRW = 6
);
    logic            start;
    logic            abort;
    logic            busy;
    logic            done;
    logic            pass;
    logic [ERRW-1:0] err_cnt;
    logic            first_fail_vld;
    logic [4:0]      first_fail_pat;
    logic [7:0]      sig;

    // Software / host side
    modport master (
        output start, abort,
        input  busy, done, pass, err_cnt, first_fail_vld, first_fail_pat, sig
    );

    // BIST controller side
    modport slave (
        input  start, abort,
        output busy, done, pass, err_cnt, first_fail_vld, first_fail_pat, sig
    );
endinterface

// File: rtl/c17_golden.sv
// Behavioural fault-free C17 model used as the compare reference.
// Latency: combinational.
// Backpressure: none.
module c17_golden
    import c17_bist_pkg::*;
(
    input  logic [4:0] pat,
    output logic [1:0] resp
);
    assign resp = c17_resp(pat);
endmodule

// File: rtl/c17_bist_ctrl.sv
// Exhaustive-pattern BIST sequencer for an external C17: apply, settle, sample, compare, compact.
// Latency: SETTLE_CYC+2 cycles per pattern; start to done pulse NPAT*(SETTLE_CYC+2)+1 cycles.
// Backpressure: none; start ignored while busy, abort returns to idle on the next edge.
module c17_bist_ctrl
    import c17_bist_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int NPAT       = 32,
    parameter int ERRW       = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    c17_bist_ctrl_if.slave       ctl,
    output logic [4:0]           pat_o,
    input  logic [1:0]           dut_resp_i
);

    localparam int          CNTW     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SETTLE_CYC - 1);
    localparam logic [4:0]  IDX_LAST = 5'(NPAT - 1);

    state_t            state;
    logic [4:0]        idx;
    logic [CNTW-1:0]   cnt;
    logic [4:0]        pat_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [ERRW-1:0]   err_q;
    logic              ffv_q;
    logic [4:0]        ffp_q;
    logic [7:0]        sig_q;
    logic [1:0]        gold_resp;
    logic              mismatch;

    c17_golden u_golden (
        .pat  (pat_q),
        .resp (gold_resp)
    );

    assign mismatch = (dut_resp_i != gold_resp);

    // Sequencer: walks patterns 0..NPAT-1, accumulates errors and signature; abort overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            cnt    <= '0;
            pat_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            ffv_q  <= 1'b0;
            ffp_q  <= '0;
            sig_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (state != ST_IDLE && ctl.abort) begin
                // partial err/first-fail/signature stay visible for debug
                state  <= ST_IDLE;
                busy_q <= 1'b0;
                pass_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ctl.start && !ctl.abort) begin
                            err_q  <= '0;
                            ffv_q  <= 1'b0;
                            ffp_q  <= '0;
                            sig_q  <= '0;
                            pass_q <= 1'b0;
                            idx    <= '0;
                            busy_q <= 1'b1;
                            state  <= ST_APPLY;
                        end
                    end
                    ST_APPLY: begin
                        pat_q <= idx;
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (cnt == CNT_LAST) begin
                            state <= ST_SAMPLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_SAMPLE: begin
                        if (mismatch) begin
                            if (err_q != '1) begin
                                err_q <= err_q + 1'b1;
                            end
                            if (!ffv_q) begin
                                ffv_q <= 1'b1;
                                ffp_q <= pat_q;
                            end
                        end
                        sig_q <= misr_step(sig_q, dut_resp_i);
                        if (idx == IDX_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= ST_APPLY;
                        end
                    end
                    ST_DONE: begin
                        // err_q already holds the final pattern's update here
                        done_q <= 1'b1;
                        pass_q <= (err_q == '0);
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign pat_o              = pat_q;
    assign ctl.busy           = busy_q;
    assign ctl.done           = done_q;
    assign ctl.pass           = pass_q;
    assign ctl.err_cnt        = err_q;
    assign ctl.first_fail_vld = ffv_q;
    assign ctl.first_fail_pat = ffp_q;
    assign ctl.sig            = sig_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Scoreboarded bench for c17_bist_ctrl with a faultable C17 model on the pattern bus.
// Latency: checks done timing against start acceptance.
// Backpressure: n/a.
module tb_c17_bist_ctrl;

    localparam int S  = 2;
    localparam int N  = 32;
    localparam int E  = 6;
    localparam int S2 = 1;
    localparam int N2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    c17_bist_ctrl_if #(.ERRW(E)) bus ();
    c17_bist_ctrl_if #(.ERRW(E)) bus2 ();

    logic [4:0] pat, pat2;
    logic [1:0] resp, resp2;

    c17_bist_ctrl #(.SETTLE_CYC(S), .NPAT(N), .ERRW(E)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctl        (bus),
        .pat_o      (pat),
        .dut_resp_i (resp)
    );

    c17_bist_ctrl #(.SETTLE_CYC(S2), .NPAT(N2), .ERRW(E)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctl        (bus2),
        .pat_o      (pat2),
        .dut_resp_i (resp2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference C17 as a truth function of the named gate inputs
    function automatic logic [1:0] ref_c17(input logic [4:0] p);
        logic g1, g2, g3, g4, g5, a, b, c, d;
        {g5, g4, g3, g2, g1} = p;
        a = !(g5 && g2);
        b = !(g5 && g1);
        c = !(a && g4);
        d = !(a && g3);
        return {!(d && c), !(b && c)};
    endfunction

    // Fault injection applied by the external C17 the bench provides
    logic [1:0] flip [32];
    logic [1:0] sa1;
    assign resp  = (ref_c17(pat) ^ flip[pat]) | sa1;
    assign resp2 = ref_c17(pat2);

    typedef struct {
        int         done_cyc;
        logic       pass;
        logic [5:0] err;
        logic       ffv;
        logic [4:0] ffp;
        logic [7:0] sig;
    } exp_t;

    exp_t sb[$];
    logic [7:0] healthy_sig;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected results of a full run over npat patterns with the current fault setup
    function automatic exp_t build_exp(input int npat);
        exp_t e;
        logic [1:0] r, g;
        e.done_cyc = 0;
        e.err = 0; e.ffv = 0; e.ffp = 0; e.sig = 0;
        for (int p = 0; p < npat; p++) begin
            g = ref_c17(5'(p));
            r = (g ^ flip[p]) | sa1;
            if (r != g) begin
                if (e.err != 6'h3F) e.err = e.err + 1;
                if (!e.ffv) begin e.ffv = 1; e.ffp = 5'(p); end
            end
            e.sig = {e.sig[6:0], 1'b0} ^ (e.sig[7] ? 8'h1D : 8'h00) ^ {6'b0, r};
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    // Pulses start; returns at the first negedge after the accepting edge
    task automatic run_start(input bit expect_done);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        if (expect_done) begin
            e = build_exp(N);
            e.done_cyc = cyc + 1 + N * (S + 2) + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600 && sb.size() != 0; i++) @(negedge clk);
        check("done_timeout_pending", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    // Monitor: pattern sequence tracking and scoreboard pop on every done pulse
    logic [4:0] pats[$];
    bit busy_prev = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.busy) begin
                if (!busy_prev) pats.delete();
                else if (pats.size() == 0 || pats[$] != pat) pats.push_back(pat);
            end
            busy_prev = bus.busy;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    int bad;
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("pass", bus.pass, e.pass);
                    check("err_cnt", bus.err_cnt, e.err);
                    check("first_fail_vld", bus.first_fail_vld, e.ffv);
                    if (e.ffv) check("first_fail_pat", bus.first_fail_pat, e.ffp);
                    check("sig", bus.sig, e.sig);
                    check("busy_at_done", bus.busy, 0);
                    bad = 0;
                    for (int i = 0; i < pats.size(); i++) if (pats[i] != 5'(i)) bad++;
                    check("pat_seq_len", pats.size(), N);
                    check("pat_seq_bad", bad, 0);
                end
            end
        end else begin
            busy_prev = 0;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_pat_o"}, pat, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_pass"}, bus.pass, 0);
        check({tag, "_err_cnt"}, bus.err_cnt, 0);
        check({tag, "_ffv"}, bus.first_fail_vld, 0);
        check({tag, "_ffp"}, bus.first_fail_pat, 0);
        check({tag, "_sig"}, bus.sig, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e2;
        logic [4:0] p2[$];
        int got;
        for (int p = 0; p < 32; p++) flip[p] = 2'b00;
        sa1 = 2'b00;
        bus.start = 0; bus.abort = 0;
        bus2.start = 0; bus2.abort = 0;
        rst_n = 0;
        #12;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1;

        // healthy run
        healthy_sig = build_exp(N).sig;
        run_start(1);
        wait_idle();

        // stuck-at-1 on G7gat
        sa1 = 2'b10;
        run_start(1);
        wait_idle();
        check("sa1_first_fail_pat", bus.first_fail_pat, 0);
        check("sa1_sig_differs", (bus.sig != healthy_sig), 1);
        sa1 = 2'b00;

        // random fault tables
        for (int r = 0; r < 5; r++) begin
            for (int p = 0; p < 32; p++)
                flip[p] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_start(1);
            wait_idle();
        end
        for (int p = 0; p < 32; p++) flip[p] = 2'b00;

        // abort at cycle 40
        run_start(0);
        repeat (39) @(negedge clk);
        bus.abort = 1;
        @(negedge clk);
        bus.abort = 0;
        check("abort_busy", bus.busy, 0);
        check("abort_pass", bus.pass, 0);
        check("abort_done", bus.done, 0);
        repeat (150) @(negedge clk);
        run_start(1);
        wait_idle();
        check("after_abort_pass", bus.pass, 1);

        // start and abort together in idle: abort wins
        @(negedge clk);
        bus.start = 1; bus.abort = 1;
        @(negedge clk);
        bus.start = 0; bus.abort = 0;
        check("start_abort_busy", bus.busy, 0);

        // start re-pulsed while busy
        run_start(1);
        repeat (9) @(negedge clk);
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        repeat (39) @(negedge clk);
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        wait_idle();

        // async reset mid-run
        run_start(0);
        repeat (69) @(negedge clk);
        #2 rst_n = 0;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1;
        run_start(1);
        wait_idle();
        check("post_reset_sig", bus.sig, healthy_sig);

        // small build: SETTLE_CYC=1, NPAT=4
        e2 = build_exp(N2);
        got = -1;
        @(negedge clk);
        bus2.start = 1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 0) bus2.start = 0;
            if (k >= 1 && bus2.busy && (p2.size() == 0 || p2[$] != pat2)) p2.push_back(pat2);
            if (bus2.done) begin got = k; break; end
        end
        check("small_done_cycle", got, N2 * (S2 + 2) + 1);
        check("small_pat_len", p2.size(), N2);
        for (int i = 0; i < p2.size() && i < N2; i++) check("small_pat", p2[i], i);
        check("small_pass", bus2.pass, 1);
        check("small_err", bus2.err_cnt, 0);
        check("small_sig", bus2.sig, e2.sig);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/c17_bist_ctrl.md
Name: c17_bist_ctrl

Overview:
Built-in self-test sequencer for the C17 NAND2 benchmark netlist (5 inputs G1gat..G5gat, 2 outputs G6gat/G7gat).
- Drives every input pattern exhaustively into an external C17 instance and waits a programmable settle time.
- Samples the response, compares it against an internal golden model, counts mismatches and compacts the responses into a MISR signature.
- Sits beside the C17 instance in fault-injection campaigns. Software starts a run and reads pass/fail, error count, first failing pattern and signature.

Parameters:
- SETTLE_CYC, 2, cycles between applying a pattern and sampling the response (min 1).
- NPAT, 32, patterns applied per run (1..32); patterns run 0..NPAT-1.
- ERRW, 6, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle run request, accepted only in IDLE
- abort  in  1  terminates a run in progress
- pat_o  out  5  applied pattern, bit order {G5gat,G4gat,G3gat,G2gat,G1gat}
- dut_resp_i  in  2  C17 response {G7gat,G6gat}
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run completion (not on abort)
- pass  out  1  high when the last completed run had err_cnt==0
- err_cnt  out  ERRW  mismatching pattern count, saturates at all-ones
- first_fail_vld  out  1  at least one mismatch this run
- first_fail_pat  out  5  pattern of the first mismatch
- sig  out  8  MISR signature of all sampled responses

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - pat_o=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_vld=0, first_fail_pat=0, sig=8'h00.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 and abort=0: clear err_cnt, first_fail_*, sig and pass; set idx=0; go to APPLY. busy=1 from the next cycle.
- APPLY: pat_o<=idx; settle counter cleared; go to SETTLE.
- SETTLE: stay SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE: register dut_resp_i and compare it with golden(pat_o).
  - Mismatch: err_cnt++ (saturating). If first_fail_vld==0, set first_fail_vld=1 and first_fail_pat=pat_o.
  - sig_next = {sig[6:0],1'b0} ^ (sig[7] ? 8'h1D : 8'h00) ^ {6'b0,dut_resp_i}.
  - idx==NPAT-1: go to DONE. Otherwise idx++ and go to APPLY.
- DONE: done=1 for exactly one cycle; pass<=(err_cnt==0 after the final update); busy=0 from the next cycle; go to IDLE.
- Latency:
  - Each pattern takes SETTLE_CYC+2 cycles.
  - start to done = NPAT*(SETTLE_CYC+2)+1 cycles; 129 with defaults.
- Results (err_cnt, first_fail_*, sig, pass) are held until the next accepted start.
- pat_o holds its last value in IDLE.
- start while busy: ignored.
- start and abort in the same IDLE cycle: abort wins, nothing starts.
- abort in any non-IDLE state: IDLE next cycle, busy=0, done not pulsed, pass=0. err_cnt, first_fail_* and sig keep their partial values.
- Saturation: err_cnt holds at 2^ERRW-1. This cannot occur with defaults (32<63).
- Async reset mid-run: immediate return to the reset values above.
- Golden model:
  - w1=~(G5&G2), w2=~(G5&G1), w3=~(w1&G4), w4=~(w1&G3).
  - G6=~(w2&w3), G7=~(w4&w3).

Decomposition:
- Package c17_bist_pkg: state enum, MISR polynomial constant 8'h1D, pattern bit-order constants, golden response function.
- Sub-module c17_golden: combinational behavioural C17 model (5-bit in, 2-bit out), instantiated once for the compare.

Test Plan:
- Healthy C17 connected, start pulse: done arrives 129 cycles after start; pass=1, err_cnt=0, first_fail_vld=0. pat_o sequence is 0..31. Pattern 5'b00000 gives resp 2'b00; pattern 5'b11111 gives resp 2'b01.
- Stuck-at-1 on G7gat (dut_resp_i[1] forced 1): err_cnt equals the number of patterns whose golden G7=0; first_fail_pat=5'b00000; pass=0. sig differs from the healthy-run signature.
- Abort asserted at cycle 40 of a run: busy=0 next cycle, done never pulses, pass=0. A new start then completes normally with pass=1.
- start re-pulsed while busy at cycles 10 and 50: run timing unchanged, done still at cycle 129, exactly one done pulse.
- rst_n low mid-run at cycle 70: all outputs return to reset values asynchronously. After release, a start yields an identical healthy signature to the first test.
- SETTLE_CYC=1, NPAT=4 build: done at 4*3+1=13 cycles after start; pat_o sequence is 0,1,2,3.
